// File: rtl/iob_regarray_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : iob_regarray_wr_arb
// Purpose  : Round-robin write arbiter with lock support in front of a
//            register array. One accepted write per cycle, registered output.
// Revision : 1.0 - initial release
// ============================================================================
module iob_regarray_wr_arb #(
    parameter int N_REQ   = 2,
    parameter int WADDR_W = 4,
    parameter int WDATA_W = 32,
    parameter int WSTRB_W = WDATA_W / 8
) (
    input  logic                       clk_i,
    input  logic                       cke_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           valid_i,
    input  logic [N_REQ-1:0]           lock_i,
    input  logic [N_REQ*WADDR_W-1:0]   addr_i,
    input  logic [N_REQ*WSTRB_W-1:0]   wstrb_i,
    input  logic [N_REQ*WDATA_W-1:0]   wdata_i,
    output logic [N_REQ-1:0]           ready_o,
    output logic                       wen_o,
    output logic [WADDR_W-1:0]         waddr_o,
    output logic [WSTRB_W-1:0]         wstrb_o,
    output logic [WDATA_W-1:0]         wdata_o,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       busy_o
);

    localparam int                IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]    N_EXT    = (IDX_W + 1)'(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_nxt;

    logic [IDX_W:0]     w_k;
    logic               w_found;
    logic [IDX_W-1:0]   w_rr_idx;
    logic               w_xfer;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [N_REQ-1:0]   w_ready;
    logic [WADDR_W-1:0] w_addr;
    logic [WSTRB_W-1:0] w_strb;
    logic [WDATA_W-1:0] w_data;

    logic               r_wen;
    logic [WADDR_W-1:0] r_waddr;
    logic [WSTRB_W-1:0] r_wstrb;
    logic [WDATA_W-1:0] r_wdata;
    logic [N_REQ-1:0]   r_grant;

    // Index after idx, wrapping back to requester 0.
    function automatic logic [IDX_W-1:0] f_inc_wrap(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_rr_idx = '0;
        w_k      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_k = {1'b0, r_ptr} + (IDX_W + 1)'(i);
            if (w_k >= N_EXT) begin
                w_k = w_k - N_EXT;
            end
            if (!w_found && valid_i[w_k[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_rr_idx = w_k[IDX_W-1:0];
            end
        end
    end

    // Pick the winner: the lock owner while locked, else the round-robin hit.
    // Nothing is accepted while the clock is disabled or reset is asserted.
    always_comb begin
        w_sel_idx = '0;
        w_xfer    = 1'b0;
        if (cke_i && !rst_i) begin
            if (r_state == ST_LOCKED) begin
                w_sel_idx = r_owner;
                w_xfer    = valid_i[r_owner];
            end else begin
                w_sel_idx = w_rr_idx;
                w_xfer    = w_found;
            end
        end
    end

    // One-hot acceptance and field mux for the selected requester.
    always_comb begin
        w_ready = '0;
        w_addr  = '0;
        w_strb  = '0;
        w_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_sel_idx == IDX_W'(k)) begin
                w_ready[k] = w_xfer;
                w_addr     = addr_i[k*WADDR_W +: WADDR_W];
                w_strb     = wstrb_i[k*WSTRB_W +: WSTRB_W];
                w_data     = wdata_i[k*WDATA_W +: WDATA_W];
            end
        end
    end

    // Next-state, pointer and owner update.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_ptr_nxt = f_inc_wrap(w_sel_idx);
                    if (lock_i[w_sel_idx]) begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_sel_idx;
                    end
                end
            end
            ST_LOCKED: begin
                // Releasing the lock ends the lock whether or not a write
                // was accepted in the same cycle.
                if (!lock_i[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = f_inc_wrap(r_owner);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers; reset wins over the clock enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (cke_i) begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Registered write port; fields hold when nothing is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_grant <= '0;
        end else if (cke_i) begin
            r_wen   <= w_xfer;
            r_grant <= w_ready;
            if (w_xfer) begin
                r_waddr <= w_addr;
                r_wstrb <= w_strb;
                r_wdata <= w_data;
            end
        end
    end

    assign ready_o = w_ready;
    assign wen_o   = r_wen;
    assign waddr_o = r_waddr;
    assign wstrb_o = r_wstrb;
    assign wdata_o = r_wdata;
    assign grant_o = r_grant;
    assign busy_o  = (r_state == ST_LOCKED);

endmodule
`default_nettype wire
